// File: rtl/imem_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Boot-time instruction memory writer. Parses a framed host byte
//             stream (sync, 16-bit word count, little-endian words, XOR
//             checksum), writes each word to sequential word addresses and
//             releases the core from reset once the frame checksum matches.
//  Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active low
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        reload,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [31:0] c_DEPTH = 32'(DEPTH_WORDS);

    state_t      r_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [15:0] r_word_cnt;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_asm;        // lanes 0..2; lane 3 goes straight to the write data
    logic [7:0]  r_chk;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_error;
    logic        r_core_rst_n;

    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_len_too_big;
    logic [15:0] w_word_next;
    logic [31:0] w_word_addr;
    logic        w_ready_state;

    // Stream is accepted in every state except the two terminal ones; the
    // reset term keeps byte_ready low while rst is asserted.
    assign w_ready_state = (r_state != S_DONE) && (r_state != S_ERR);
    assign byte_ready    = rst & w_ready_state;
    assign w_accept      = byte_valid & byte_ready;

    assign w_len_full    = {byte_in, r_len_lo};
    assign w_len_too_big = ({16'd0, w_len_full} > c_DEPTH);
    assign w_word_next   = r_word_cnt + 16'd1;
    assign w_word_addr   = BASE_ADDR + {14'd0, r_word_cnt, 2'b00};

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = r_done;
    assign error      = r_error;
    assign core_rst_n = r_core_rst_n;

    // Frame parser, word assembly, write port and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_word_cnt   <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_asm        <= 24'd0;
            r_chk        <= 8'd0;
            r_we         <= 1'b0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= 32'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per assembled word.
            r_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept && (byte_in == SYNC_BYTE)) begin
                        r_state <= S_LEN_LO;
                        r_chk   <= 8'd0;   // every frame starts a fresh checksum
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len_lo <= byte_in;
                        r_state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len      <= w_len_full;
                        r_word_cnt <= 16'd0;
                        r_byte_idx <= 2'd0;
                        if (w_len_full == 16'd0) begin
                            r_state <= S_CHECK;
                        end else if (w_len_too_big) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_chk      <= r_chk ^ byte_in;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= byte_in;
                            2'd1: r_asm[15:8]  <= byte_in;
                            2'd2: r_asm[23:16] <= byte_in;
                            2'd3: begin
                                r_we       <= 1'b1;
                                r_wdata    <= {byte_in, r_asm};
                                r_addr     <= w_word_addr;
                                r_word_cnt <= w_word_next;
                                if (w_word_next == r_len) begin
                                    r_state <= S_CHECK;
                                end
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (byte_in == r_chk) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_core_rst_n <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (reload) begin
                        r_state      <= S_IDLE;
                        r_done       <= 1'b0;
                        r_core_rst_n <= 1'b0;
                        r_chk        <= 8'd0;
                    end
                end
                S_ERR: begin
                    if (reload) begin
                        r_state <= S_IDLE;
                        r_error <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
